oled_stream_tx: RTL and testbench
=================================

# oled_stream_tx

Pixel-streaming transmitter for the 96x64 SSD1331 PmodOLED. It walks the screen in raster order and drives `x`/`y` to the screen-content logic, such as the game screen sequencer. It samples the returned 16-bit RGB565 `oled_data` and serialises each pixel onto the panel's SPI pins. With the init option compiled in, it also performs the panel power-up reset and command sequence before streaming begins.

## Interface
- `CLK_DIV`, 2: `clk` cycles per SCLK half-period (≥1); bit period = 2·CLK_DIV.
- `RESET_CYCLES`, 16'd1000: duration of the `res_n` low phase and of the post-reset wait.
- `clk` input 1: system clock; all logic on posedge.
- `reset` input 1: synchronous, active-high reset.
- `oled_data` input 16: RGB565 colour for the current `x`,`y`.
- `x` output 7: pixel column requested, 0..95.
- `y` output 6: pixel row requested, 0..63.
- `frame_begin` output 1: one-cycle pulse when pixel (0,0) is loaded.
- `sending_pixels` output 1: high while in the streaming phase.
- `cs` output 1: SPI chip select, active low.
- `sclk` output 1: SPI clock; idles high.
- `sdin` output 1: SPI data, MSB first.
- `d_cn` output 1: 0 = command byte, 1 = pixel data.
- `res_n` output 1: panel reset, active low.
- `vccen` output 1: panel VCC enable.
- `pmoden` output 1: Pmod power enable.

## Operation
- Reset values:
  - `cs`=1, `sclk`=1, `sdin`=0, `d_cn`=0.
  - `res_n`=0, `vccen`=0, `pmoden`=0.
  - `x`=0, `y`=0.
  - `frame_begin`=0, `sending_pixels`=0.
  - All counters are cleared.
- States: `PWR_UP` → `RST_LOW` → `RST_WAIT` → `CMD_LOAD` ⇄ `CMD_SHIFT` → `VCC_ON` → `PIX_LOAD` ⇄ `PIX_SHIFT`.
- `PWR_UP`: set `pmoden`=1, hold `res_n`=0; advance after 1 cycle.
- `RST_LOW`: keep `res_n`=0 for RESET_CYCLES. Then `RST_WAIT`: `res_n`=1 for RESET_CYCLES.
- `CMD_LOAD`: fetch the next init-ROM byte, set `d_cn`=0, `cs`=0. `CMD_SHIFT` sends 8 bits. After the last ROM byte, go to `VCC_ON`.
- `VCC_ON`: set `vccen`=1, send display-on command 0xAF, then enter `PIX_LOAD`.
- `PIX_LOAD`:
  - Register `oled_data` into the 16-bit shift register and set `d_cn`=1, `cs`=0, `sending_pixels`=1.
  - If `x`=0 and `y`=0, pulse `frame_begin`.
- `PIX_SHIFT`:
  - Shift 16 bits MSB first.
  - After the last bit, advance the raster: `x`+1; when `x`=95, set `x`=0 and `y`+1; when `y`=63 and `x`=95, wrap to (0,0).
  - Return to `PIX_LOAD`.
- Streaming is continuous and never terminates; `cs` stays low across consecutive words.
- Raster counters saturate at their legal range by construction; `x`=96..127 and `y`=64 are never emitted.
- `oled_data` is sampled only in `PIX_LOAD`; changes at any other time are ignored.

## Timing
- SPI mode 3:
  - `sclk` falls, `sdin` updates on the same `clk` edge, and `sclk` rises CLK_DIV cycles later; the panel samples on the rising edge.
  - Each bit lasts 2·CLK_DIV cycles.
- Per-item cost:
  - Pixel = 1 load cycle + 32·CLK_DIV cycles; the default is 65 cycles.
  - Command byte = 1 + 16·CLK_DIV cycles.
- `x`,`y` update on the same edge that ends the last bit. `PIX_LOAD` is the next cycle, so `oled_data` must be valid 1 cycle after `x`,`y` change (purely combinational screen logic meets this).
- `frame_begin` pulses once per 6144 pixels; the default frame period is 6144·65 = 399360 cycles.
- `reset` asserted in any state forces all reset values on the next edge, including mid-byte and mid-pixel. The full init sequence then restarts; no partial word completes.
- Simultaneous `reset` and last-bit completion: reset wins and the raster does not advance.

## Configuration
- `OLED_INIT_EN` defined:
  - Full `PWR_UP`..`VCC_ON` sequence as above.
- `OLED_INIT_EN` undefined:
  - After reset, the block goes directly to `PIX_LOAD` on the first cycle, with `res_n`=1, `pmoden`=1, `vccen`=1 from that cycle on.
  - The init ROM and the reset timer are not synthesised.
  - Streaming timing is identical.

## Structure
- Package `oled_pkg`:
  - `OLED_W`=96, `OLED_H`=64.
  - State enum `oled_state_t`.
  - Init command ROM constant `OLED_INIT_CMDS` and its length.
  - Display-on opcode 0xAF.
- Sub-module `spi_shifter`:
  - Parameter `W` (8 or 16), plus CLK_DIV.
  - Ports: `load`, `din`; outputs `sclk`, `sdin`, `done`.
  - Instantiated once, with width selected by `d_cn`; alternatively a 16-bit shifter loading commands into the upper byte.

## Test plan
- With `OLED_INIT_EN` defined, deassert `reset`. Required response:
  - `res_n` stays 0 for 1001 cycles, then 1.
  - The SPI capture with `d_cn`=0 equals `OLED_INIT_CMDS` followed by 0xAF.
  - `vccen` rises before 0xAF is sent.
- Drive `oled_data` = {x,y,3'b0} combinationally. Every captured word with `d_cn`=1 matches the `x`,`y` at its load, e.g. pixel (5,2) → 0x0A10.
- Count pixels between `frame_begin` pulses: exactly 6144 pixels, 399360 cycles at CLK_DIV=2. The last word before a pulse carries (95,63).
- Assert `reset` in the 7th bit of a pixel word. Required response:
  - Next cycle `cs`=1, `sclk`=1, `x`=`y`=0.
  - The capture shows no 16-bit word completed.
- With CLK_DIV=1 and `OLED_INIT_EN` undefined: the first `frame_begin` occurs 1 cycle after `reset` falls, and each pixel takes 33 cycles.
- Hold `oled_data` at 0xFFFF, then toggle it to 0x0000 except in `PIX_LOAD` cycles. All captured pixels equal 0xFFFF.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared constants, state encoding and init-command ROM for the SSD1331
// PmodOLED pixel streamer (oled_stream_tx).
package oled_pkg;

  localparam int OLED_W      = 96;
  localparam int OLED_H      = 64;
  localparam int OLED_PIXELS = OLED_W * OLED_H;

  typedef enum logic [2:0] {
    PWR_UP,
    RST_LOW,
    RST_WAIT,
    CMD_LOAD,
    CMD_SHIFT,
    VCC_ON,
    PIX_LOAD,
    PIX_SHIFT
  } oled_state_t;

  // Panel bring-up: display off, 96x64 RGB565 remap, contrast and timing setup.
  localparam int OLED_INIT_LEN = 37;
  localparam logic [OLED_INIT_LEN*8-1:0] OLED_INIT_CMDS = {
    8'hAE,
    8'hA0, 8'h72,
    8'hA1, 8'h00,
    8'hA2, 8'h00,
    8'hA4,
    8'hA8, 8'h3F,
    8'hAD, 8'h8E,
    8'hB0, 8'h0B,
    8'hB1, 8'h31,
    8'hB3, 8'hF0,
    8'h8A, 8'h64,
    8'h8B, 8'h78,
    8'h8C, 8'h64,
    8'hBB, 8'h3A,
    8'hBE, 8'h3E,
    8'h87, 8'h06,
    8'h81, 8'h91,
    8'h82, 8'h50,
    8'h83, 8'h7D,
    8'h2E
  };

  // Index counts the ROM bytes plus the trailing display-on command.
  localparam int OLED_CMD_IDX_W = $clog2(OLED_INIT_LEN + 2);

  localparam logic [7:0] OLED_DISP_ON = 8'hAF;

  // Byte idx of the init ROM, first command at index 0.
  function automatic logic [7:0] oled_init_byte(input logic [OLED_CMD_IDX_W-1:0] idx);
    if (int'(idx) < OLED_INIT_LEN) begin
      return OLED_INIT_CMDS[(OLED_INIT_LEN - 1 - int'(idx)) * 8 +: 8];
    end
    return 8'h00;
  endfunction

endpackage

// File: rtl/oled_stream_tx_spi_shifter.sv
// SPI mode-3 serialiser: sclk idles high, falls together with each new sdin
// bit and rises CLK_DIV cycles later. short_word sends only the upper half.
module spi_shifter #(
  parameter int W       = 16,
  parameter int CLK_DIV = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         short_word,
  input  logic [W-1:0] din,
  output logic         sclk,
  output logic         sdin,
  output logic         done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(W);

  logic [W-1:0]     shreg_q, shreg_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             sclk_q, sclk_d;
  logic             busy_q, busy_d;
  logic             div_last;

  assign div_last = (div_q == DIV_W'(CLK_DIV - 1));
  // High on the edge that ends the high half of the final bit.
  assign done     = busy_q & sclk_q & div_last & (bit_q == '0);
  assign sclk     = sclk_q;
  assign sdin     = shreg_q[W-1];

  // Half-period divider and bit sequencing.
  always_comb begin
    shreg_d = shreg_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    busy_d  = busy_q;
    if (load) begin
      shreg_d = din;
      sclk_d  = 1'b0;
      div_d   = '0;
      busy_d  = 1'b1;
      bit_d   = short_word ? BIT_W'(W/2 - 1) : BIT_W'(W - 1);
    end else if (busy_q) begin
      if (div_last) begin
        div_d = '0;
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else if (bit_q == '0) begin
          busy_d = 1'b0;
        end else begin
          sclk_d  = 1'b0;
          shreg_d = {shreg_q[W-2:0], 1'b0};
          bit_d   = bit_q - 1'b1;
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // State registers; reset parks sclk high with sdin low.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: rtl/oled_stream_tx.sv
// Raster-order RGB565 streamer for the 96x64 SSD1331 PmodOLED.
// Define OLED_INIT_EN to include the panel power-up reset and command
// sequence; otherwise streaming starts on the first cycle after reset.
module oled_stream_tx
  import oled_pkg::*;
#(
  parameter int          CLK_DIV      = 2,
  parameter logic [15:0] RESET_CYCLES = 16'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] oled_data,
  output logic [6:0]  x,
  output logic [5:0]  y,
  output logic        frame_begin,
  output logic        sending_pixels,
  output logic        cs,
  output logic        sclk,
  output logic        sdin,
  output logic        d_cn,
  output logic        res_n,
  output logic        vccen,
  output logic        pmoden
);

  if (CLK_DIV < 1 || RESET_CYCLES == 16'd0) begin : g_param_check
    $error("oled_stream_tx: CLK_DIV and RESET_CYCLES must be at least 1");
  end

`ifdef OLED_INIT_EN
  localparam oled_state_t START_STATE = PWR_UP;
`else
  localparam oled_state_t START_STATE = PIX_LOAD;
`endif

  oled_state_t state_q, state_d;
  logic [6:0]  x_q, x_d;
  logic [5:0]  y_q, y_d;
  logic        frame_begin_q, frame_begin_d;
  logic        sending_q, sending_d;
  logic        cs_q, cs_d;
  logic        d_cn_q, d_cn_d;
  logic        res_n_q, res_n_d;
  logic        vccen_q, vccen_d;
  logic        pmoden_q, pmoden_d;
`ifdef OLED_INIT_EN
  logic [15:0]               timer_q, timer_d;
  logic [OLED_CMD_IDX_W-1:0] cmd_idx_q, cmd_idx_d;
`endif

  logic        sh_load;
  logic        sh_short;
  logic [15:0] sh_din;
  logic        sh_done;

  // Commands go out through the same 16-bit shifter, left-justified.
  spi_shifter #(
    .W       (16),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .load       (sh_load),
    .short_word (sh_short),
    .din        (sh_din),
    .sclk       (sclk),
    .sdin       (sdin),
    .done       (sh_done)
  );

  // Sequencer next-state: init steps, then endless pixel streaming.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    frame_begin_d = 1'b0;
    sending_d     = sending_q;
    cs_d          = cs_q;
    d_cn_d        = d_cn_q;
    res_n_d       = res_n_q;
    vccen_d       = vccen_q;
    pmoden_d      = pmoden_q;
    sh_load       = 1'b0;
    sh_short      = 1'b0;
    sh_din        = '0;
`ifdef OLED_INIT_EN
    timer_d       = timer_q;
    cmd_idx_d     = cmd_idx_q;
`endif
    case (state_q)
`ifdef OLED_INIT_EN
      PWR_UP: begin
        pmoden_d = 1'b1;
        timer_d  = '0;
        state_d  = RST_LOW;
      end
      RST_LOW: begin
        if (timer_q == RESET_CYCLES - 16'd1) begin
          timer_d = '0;
          res_n_d = 1'b1;
          state_d = RST_WAIT;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      RST_WAIT: begin
        if (timer_q == RESET_CYCLES - 16'd1) begin
          timer_d = '0;
          state_d = CMD_LOAD;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      CMD_LOAD: begin
        sh_load   = 1'b1;
        sh_short  = 1'b1;
        sh_din    = {oled_init_byte(cmd_idx_q), 8'h00};
        cmd_idx_d = cmd_idx_q + 1'b1;
        cs_d      = 1'b0;
        d_cn_d    = 1'b0;
        state_d   = CMD_SHIFT;
      end
      CMD_SHIFT: begin
        if (sh_done) begin
          if (cmd_idx_q == OLED_CMD_IDX_W'(OLED_INIT_LEN)) begin
            // Panel VCC comes up before the display-on command is sent.
            vccen_d = 1'b1;
            state_d = VCC_ON;
          end else if (cmd_idx_q == OLED_CMD_IDX_W'(OLED_INIT_LEN + 1)) begin
            state_d = PIX_LOAD;
          end else begin
            state_d = CMD_LOAD;
          end
        end
      end
      VCC_ON: begin
        sh_load   = 1'b1;
        sh_short  = 1'b1;
        sh_din    = {OLED_DISP_ON, 8'h00};
        cmd_idx_d = cmd_idx_q + 1'b1;
        state_d   = CMD_SHIFT;
      end
`endif
      PIX_LOAD: begin
        sh_load       = 1'b1;
        sh_din        = oled_data;
        cs_d          = 1'b0;
        d_cn_d        = 1'b1;
        sending_d     = 1'b1;
        res_n_d       = 1'b1;
        pmoden_d      = 1'b1;
        vccen_d       = 1'b1;
        frame_begin_d = (x_q == '0) && (y_q == '0);
        state_d       = PIX_SHIFT;
      end
      PIX_SHIFT: begin
        if (sh_done) begin
          if (x_q == 7'(OLED_W - 1)) begin
            x_d = '0;
            y_d = (y_q == 6'(OLED_H - 1)) ? '0 : y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
          state_d = PIX_LOAD;
        end
      end
      default: state_d = START_STATE;
    endcase
  end

  // Registered state and outputs; reset aborts any word in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= START_STATE;
      x_q           <= '0;
      y_q           <= '0;
      frame_begin_q <= 1'b0;
      sending_q     <= 1'b0;
      cs_q          <= 1'b1;
      d_cn_q        <= 1'b0;
      res_n_q       <= 1'b0;
      vccen_q       <= 1'b0;
      pmoden_q      <= 1'b0;
`ifdef OLED_INIT_EN
      timer_q       <= '0;
      cmd_idx_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_begin_q <= frame_begin_d;
      sending_q     <= sending_d;
      cs_q          <= cs_d;
      d_cn_q        <= d_cn_d;
      res_n_q       <= res_n_d;
      vccen_q       <= vccen_d;
      pmoden_q      <= pmoden_d;
`ifdef OLED_INIT_EN
      timer_q       <= timer_d;
      cmd_idx_q     <= cmd_idx_d;
`endif
    end
  end

  assign x              = x_q;
  assign y              = y_q;
  assign frame_begin    = frame_begin_q;
  assign sending_pixels = sending_q;
  assign cs             = cs_q;
  assign d_cn           = d_cn_q;
  assign res_n          = res_n_q;
  assign vccen          = vccen_q;
  assign pmoden         = pmoden_q;

endmodule

// File: tb/tb_oled_stream_tx.sv
// Bench for oled_stream_tx (works with or without OLED_INIT_EN).
// Expected outputs come from a cycle-timing model of the raster/SPI rules.
module tb_oled_stream_tx;
  import oled_pkg::*;

  localparam int CD = 2;
  localparam int RC = 1000;
  localparam int P  = 32 * CD + 1;   // cycles per pixel
  localparam int Q  = 16 * CD + 1;   // cycles per command byte
  localparam int L  = OLED_INIT_LEN;
`ifdef OLED_INIT_EN
  localparam int S  = 2 * RC + 1 + (L + 1) * Q;  // cycle of the first PIX_LOAD
`else
  localparam int S  = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] oled_data;
  logic [6:0]  x;
  logic [5:0]  y;
  logic        frame_begin, sending_pixels, cs, sclk, sdin, d_cn, res_n, vccen, pmoden;

  logic        mode;        // 0: data = {x,y,000}; 1: 0xFFFF only in load cycles
  logic [15:0] drv;
  int          cyc = 0;
  logic        started = 1'b0;
  int          total = 0;
  int          bad = 0;

  int          pix_n = 0, pix_total = 0, cmd_n = 0, bitcnt = 0;
  logic [15:0] shw = '0;
  logic        sclk_prev = 1'b1;
  logic [15:0] cap [0:255];
  logic [7:0]  cmds [0:63];

  always #5 clk = ~clk;

  assign oled_data = mode ? drv : {x, y, 3'b000};

  oled_stream_tx #(
    .CLK_DIV      (CD),
    .RESET_CYCLES (16'(RC))
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .oled_data      (oled_data),
    .x              (x),
    .y              (y),
    .frame_begin    (frame_begin),
    .sending_pixels (sending_pixels),
    .cs             (cs),
    .sclk           (sclk),
    .sdin           (sdin),
    .d_cn           (d_cn),
    .res_n          (res_n),
    .vccen          (vccen),
    .pmoden         (pmoden)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Word the panel must receive for the k-th pixel since reset.
  function automatic int pix_word(input int k);
    int kk;
    kk = k % OLED_PIXELS;
    if (mode) return 'hFFFF;
    return ((kk % OLED_W) << 9) | ((kk / OLED_W) << 3);
  endfunction

  // Cycles since reset was last sampled high.
  always @(posedge clk) begin
    if (reset) begin
      cyc     <= 0;
      started <= 1'b1;
    end else begin
      cyc <= cyc + 1;
    end
  end

  // Mode-1 data: 0xFFFF only in the cycle whose closing edge loads a pixel.
  always @(negedge clk) begin
    if (cyc >= S && ((cyc - S) % P) == 0) drv = 16'hFFFF;
    else                                   drv = 16'h0000;
  end

  // Per-cycle comparison against the timing model, plus SPI word capture.
  int c, cp, k, p, kk, ex, ey, w;
  always @(negedge clk) begin
    if (started) begin
      c = cyc;
      if (c == 0) begin
        pix_n = 0;
        cmd_n = 0;
      end
      if (c <= S) begin
        chk("x_idle", int'(x), 0);
        chk("y_idle", int'(y), 0);
        chk("frame_begin_idle", int'(frame_begin), 0);
        chk("sending_idle", int'(sending_pixels), 0);
        chk("d_cn_idle", int'(d_cn), 0);
`ifdef OLED_INIT_EN
        chk("pmoden_init", int'(pmoden), (c >= 1) ? 1 : 0);
        chk("res_n_init", int'(res_n), (c >= 1 + RC) ? 1 : 0);
        chk("vccen_init", int'(vccen), (c >= S - Q) ? 1 : 0);
        chk("cs_init", int'(cs), (c < 2 * RC + 2) ? 1 : 0);
        if (c < 2 * RC + 2) chk("sclk_init", int'(sclk), 1);
`else
        chk("pmoden_rst", int'(pmoden), 0);
        chk("res_n_rst", int'(res_n), 0);
        chk("vccen_rst", int'(vccen), 0);
        chk("cs_rst", int'(cs), 1);
        chk("sclk_rst", int'(sclk), 1);
        chk("sdin_rst", int'(sdin), 0);
`endif
      end else begin
        cp = c - S - 1;
        k  = cp / P;
        p  = cp % P;
        kk = ((p == P - 1) ? k + 1 : k) % OLED_PIXELS;
        ex = kk % OLED_W;
        ey = kk / OLED_W;
        chk("x", int'(x), ex);
        chk("y", int'(y), ey);
        chk("frame_begin", int'(frame_begin), (p == 0 && (k % OLED_PIXELS) == 0) ? 1 : 0);
        chk("sending", int'(sending_pixels), 1);
        chk("cs", int'(cs), 0);
        chk("d_cn", int'(d_cn), 1);
        chk("res_n", int'(res_n), 1);
        chk("pmoden", int'(pmoden), 1);
        chk("vccen", int'(vccen), 1);
        if (p == P - 1) begin
          chk("sclk_load", int'(sclk), 1);
        end else begin
          chk("sclk", int'(sclk), (p / CD) % 2);
          w = pix_word(k);
          chk("sdin", int'(sdin), (w >> (15 - p / (2 * CD))) & 1);
        end
      end

      if (cs) begin
        bitcnt = 0;
      end else if (!sclk_prev && sclk) begin
        shw = {shw[14:0], sdin};
        bitcnt++;
        if (d_cn && bitcnt == 16) begin
          chk("pixel_word", int'(shw), pix_word(pix_n));
          if (pix_n < 256) cap[pix_n] = shw;
          pix_n++;
          pix_total++;
          bitcnt = 0;
        end else if (!d_cn && bitcnt == 8) begin
`ifdef OLED_INIT_EN
          chk("cmd_byte", int'(shw[7:0]),
              (cmd_n < L) ? int'(oled_init_byte(OLED_CMD_IDX_W'(cmd_n))) : 'hAF);
          chk("vccen_at_cmd", int'(vccen), (cmd_n >= L) ? 1 : 0);
          if (cmd_n < 64) cmds[cmd_n] = shw[7:0];
`endif
          cmd_n++;
          bitcnt = 0;
        end
      end
      sclk_prev = sclk;
    end
  end

  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc != n && guard < 60000) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_cycle", cyc, n);
  endtask

  int snap;
  initial begin
    reset = 1'b1;
    mode  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs", int'(cs), 1);
    chk("rst_sclk", int'(sclk), 1);
    chk("rst_res_n", int'(res_n), 0);
    reset = 1'b0;

`ifdef OLED_INIT_EN
    wait_cyc(1000);
    chk("res_n_low_1000", int'(res_n), 0);
    wait_cyc(1001);
    chk("res_n_high_1001", int'(res_n), 1);
`endif
    wait_cyc(S + 1);
    chk("first_frame_begin", int'(frame_begin), 1);
`ifdef OLED_INIT_EN
    chk("cmd_count", cmd_n, L + 1);
    chk("cmd_first", int'(cmds[0]), 'hAE);
    chk("cmd_second", int'(cmds[1]), 'hA0);
    chk("cmd_last_rom", int'(cmds[L - 1]), 'h2E);
    chk("cmd_disp_on", int'(cmds[L]), 'hAF);
`endif
    wait_cyc(S + 2);
    chk("frame_begin_one_cycle", int'(frame_begin), 0);
    wait_cyc(S + 64);
    chk("x_before_65", int'(x), 0);
    wait_cyc(S + 65);
    chk("x_after_65", int'(x), 1);

    wait_cyc(S + 1 + 200 * P);
    chk("pix_count_200", pix_n, 200);
    chk("pix_5_2", int'(cap[2 * 96 + 5]), 'h0A10);
    chk("pix_95_0", int'(cap[95]), 'hBE00);
    chk("pix_0_1", int'(cap[96]), 'h0008);

    // Abort pixel 203 during its 7th bit.
    wait_cyc(S + 1 + 203 * P + 6 * 2 * CD + 1);
    snap  = pix_total;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_cs", int'(cs), 1);
    chk("abort_sclk", int'(sclk), 1);
    chk("abort_x", int'(x), 0);
    chk("abort_y", int'(y), 0);
    repeat (2) @(negedge clk);
    chk("abort_no_word", pix_total, snap);
    chk("abort_bits_dropped", bitcnt, 0);

    mode  = 1'b1;
    reset = 1'b0;
    wait_cyc(S + 1 + 20 * P);
    chk("hold_count_20", pix_n, 20);
    chk("hold_pix_5", int'(cap[5]), 'hFFFF);
    chk("hold_pix_19", int'(cap[19]), 'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
